// File: rtl/imem_loader_if.sv
// Byte-stream / instruction-memory write bundle for imem_loader.
// master: stream source + memory side (start, byte in; writes, status out); slave: loader.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                  start_i;
  logic [7:0]            byte_i;
  logic                  byte_valid_i;
  logic                  byte_ready_o;
  logic                  we_o;
  logic [ADDR_WIDTH-1:0] waddr_o;
  logic [DATA_WIDTH-1:0] wdata_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  err_o;
  logic                  cpu_hold_o;

  modport master (
    output start_i, byte_i, byte_valid_i,
    input  byte_ready_o, we_o, waddr_o, wdata_o,
    input  busy_o, done_o, err_o, cpu_hold_o
  );

  modport slave (
    input  start_i, byte_i, byte_valid_i,
    output byte_ready_o, we_o, waddr_o, wdata_o,
    output busy_o, done_o, err_o, cpu_hold_o
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory programmer: parses {len, LE words, xor csum} frames.
// Ports: clk_i, rst_i (async, active-high), bus (imem_loader_if.slave).
module imem_loader #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int SPACE_WIDTH = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  imem_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA,
    S_CHECK, S_DONE, S_ERROR
  } state_e;

  localparam int IW = SPACE_WIDTH + 1;
  localparam logic [16:0] MAX_WORDS = 17'(1) << SPACE_WIDTH;

  state_e                state_q, state_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [15:0]           len_q, len_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic [23:0]           word_q, word_d;
  logic [7:0]            csum_q, csum_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic        ready;
  logic        hs;
  logic [15:0] n_words;

  assign ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                 (state_q == S_DATA)   || (state_q == S_CHECK);
  assign hs      = bus.byte_valid_i && ready;
  assign n_words = {bus.byte_i, len_lo_q};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      len_lo_q <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      bcnt_q   <= '0;
      word_q   <= '0;
      csum_q   <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      bcnt_q   <= bcnt_d;
      word_q   <= word_d;
      csum_q   <= csum_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    idx_d    = idx_q;
    bcnt_d   = bcnt_q;
    word_d   = word_q;
    csum_d   = csum_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.start_i) begin
          state_d = S_LEN_LO;
          idx_d   = '0;
          csum_d  = '0;
          bcnt_d  = '0;
        end
      end
      S_LEN_LO: begin
        if (hs) begin
          len_lo_d = bus.byte_i;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (hs) begin
          len_d = n_words;
          if (n_words == 16'd0)
            state_d = S_CHECK;
          else if ({1'b0, n_words} > MAX_WORDS)
            state_d = S_ERROR;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (hs) begin
          csum_d = csum_q ^ bus.byte_i;
          bcnt_d = bcnt_q + 2'd1;
          unique case (bcnt_q)
            2'd0: word_d[7:0]   = bus.byte_i;
            2'd1: word_d[15:8]  = bus.byte_i;
            2'd2: word_d[23:16] = bus.byte_i;
            default: begin
              // 4th byte: register the write, it appears next cycle.
              we_d    = 1'b1;
              waddr_d = '0;
              waddr_d[SPACE_WIDTH+1:0] = {idx_q[SPACE_WIDTH-1:0], 2'b00};
              wdata_d = DATA_WIDTH'({bus.byte_i, word_q});
              idx_d   = idx_q + 1'b1;
              if (16'(idx_q) + 16'd1 == len_q)
                state_d = S_CHECK;
            end
          endcase
        end
      end
      S_CHECK: begin
        if (hs)
          state_d = (bus.byte_i == csum_q) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.byte_ready_o = ready;
  assign bus.busy_o       = ready;
  assign bus.we_o         = we_q;
  assign bus.waddr_o      = waddr_q;
  assign bus.wdata_o      = wdata_q;
  assign bus.done_o       = (state_q == S_DONE);
  assign bus.err_o        = (state_q == S_ERROR);
  assign bus.cpu_hold_o   = (state_q != S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame vector table plus
// long-image, reset-mid-frame and start-mid-frame sequences.
module tb_imem_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

  imem_loader #(
    .ADDR_WIDTH(10), .DATA_WIDTH(32), .SPACE_WIDTH(8)
  ) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [9:0]  wa_q[$];
  logic [31:0] wd_q[$];
  int          b2b = 0;
  logic        prev_we = 1'b0;

  always @(negedge clk) begin
    if (bus.we_o && prev_we) b2b++;
    prev_we <= bus.we_o;
    if (bus.we_o) begin
      wa_q.push_back(bus.waddr_o);
      wd_q.push_back(bus.wdata_o);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_ready"}, 32'(bus.byte_ready_o), 0);
    chk({nm, "_we"},    32'(bus.we_o), 0);
    chk({nm, "_waddr"}, 32'(bus.waddr_o), 0);
    chk({nm, "_wdata"}, bus.wdata_o, 0);
    chk({nm, "_busy"},  32'(bus.busy_o), 0);
    chk({nm, "_done"},  32'(bus.done_o), 0);
    chk({nm, "_err"},   32'(bus.err_o), 0);
    chk({nm, "_hold"},  32'(bus.cpu_hold_o), 1);
  endtask

  // Called and returns at a falling edge; one byte per cycle when gap=0.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    if (gap > 0) begin
      bus.byte_valid_i = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bus.byte_i       = b;
    bus.byte_valid_i = 1'b1;
    t = 0;
    while (!bus.byte_ready_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.byte_ready_o) begin
      chk("ready_timeout", 32'(bus.byte_ready_o), 1);
      bus.byte_valid_i = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_start();
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [7:0]  len_lo;
    logic [7:0]  len_hi;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  csum;
    bit          early;
    bit          exp_done;
    int          exp_wr;
  } vec_t;

  vec_t vecs[7];
  logic [31:0] img[256];

  initial begin
    logic [31:0] w;
    logic [7:0]  cs;
    int          bad;

    // 13^00^00^00^93^00^10^00 = 0x90
    vecs[0] = '{"two_ok",   8'h02, 8'h00, 2, 32'h13, 32'h00100093,
                8'h90, 1'b0, 1'b1, 2};
    vecs[1] = '{"two_bad",  8'h02, 8'h00, 2, 32'h13, 32'h00100093,
                8'h81, 1'b0, 1'b0, 2};
    vecs[2] = '{"two_80",   8'h02, 8'h00, 2, 32'h13, 32'h00100093,
                8'h80, 1'b0, 1'b0, 2};
    vecs[3] = '{"zero_ok",  8'h00, 8'h00, 0, 32'h0, 32'h0,
                8'h00, 1'b0, 1'b1, 0};
    vecs[4] = '{"zero_bad", 8'h00, 8'h00, 0, 32'h0, 32'h0,
                8'h01, 1'b0, 1'b0, 0};
    // EF^BE^AD^DE = 0x22
    vecs[5] = '{"one_ok",   8'h01, 8'h00, 1, 32'hDEADBEEF, 32'h0,
                8'h22, 1'b0, 1'b1, 1};
    vecs[6] = '{"len257",   8'h01, 8'h01, 0, 32'h0, 32'h0,
                8'h00, 1'b1, 1'b0, 0};

    bus.start_i      = 1'b0;
    bus.byte_i       = 8'h00;
    bus.byte_valid_i = 1'b0;

    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("idle");

    for (int i = 0; i < 7; i++) begin
      wa_q.delete();
      wd_q.delete();
      do_start();
      chk({vecs[i].name, "_busy1"}, 32'(bus.busy_o), 1);
      chk({vecs[i].name, "_done0"}, 32'(bus.done_o), 0);
      chk({vecs[i].name, "_err0"},  32'(bus.err_o), 0);
      chk({vecs[i].name, "_hold0"}, 32'(bus.cpu_hold_o), 1);
      send_byte(vecs[i].len_lo, 0);
      send_byte(vecs[i].len_hi, 0);
      if (vecs[i].early) begin
        chk({vecs[i].name, "_ready"}, 32'(bus.byte_ready_o), 0);
      end else begin
        for (int j = 0; j < vecs[i].nw; j++) begin
          w = (j == 0) ? vecs[i].w0 : vecs[i].w1;
          for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 0);
        end
        send_byte(vecs[i].csum, 0);
      end
      bus.byte_valid_i = 1'b0;
      @(negedge clk);
      chk({vecs[i].name, "_done"}, 32'(bus.done_o), 32'(vecs[i].exp_done));
      chk({vecs[i].name, "_err"},  32'(bus.err_o), 32'(!vecs[i].exp_done));
      chk({vecs[i].name, "_hold"}, 32'(bus.cpu_hold_o), 32'(!vecs[i].exp_done));
      chk({vecs[i].name, "_busy"}, 32'(bus.busy_o), 0);
      chk({vecs[i].name, "_nwr"},  32'(wa_q.size()), 32'(vecs[i].exp_wr));
      for (int j = 0; j < vecs[i].exp_wr && j < wa_q.size(); j++) begin
        w = (j == 0) ? vecs[i].w0 : vecs[i].w1;
        chk($sformatf("%s_addr%0d", vecs[i].name, j), 32'(wa_q[j]), 32'(4 * j));
        chk($sformatf("%s_data%0d", vecs[i].name, j), wd_q[j], w);
      end
    end

    // Full 256-word image with random gaps.
    wa_q.delete();
    wd_q.delete();
    cs = 8'h00;
    for (int j = 0; j < 256; j++) begin
      img[j] = $urandom;
      cs = cs ^ img[j][7:0] ^ img[j][15:8] ^ img[j][23:16] ^ img[j][31:24];
    end
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    for (int j = 0; j < 256; j++)
      for (int k = 0; k < 4; k++)
        send_byte(img[j][8*k +: 8], int'($urandom_range(0, 3)));
    send_byte(cs, int'($urandom_range(0, 3)));
    bus.byte_valid_i = 1'b0;
    @(negedge clk);
    chk("big_nwr",  32'(wa_q.size()), 256);
    chk("big_last", (wa_q.size() == 256) ? 32'(wa_q[255]) : 32'hFFFF, 32'h3FC);
    bad = 0;
    for (int j = 0; j < 256 && j < wa_q.size(); j++)
      if (wa_q[j] !== 10'(4 * j) || wd_q[j] !== img[j]) bad++;
    chk("big_data", 32'(bad), 0);
    chk("big_b2b",  32'(b2b), 0);
    chk("big_done", 32'(bus.done_o), 1);
    chk("big_hold", 32'(bus.cpu_hold_o), 0);

    // Reset after two payload bytes, then a clean reload with a stray start.
    do_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    bus.byte_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wa_q.delete();
    wd_q.delete();
    do_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    bus.start_i = 1'b1;
    w = 32'h13;
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 0);
    w = 32'h00100093;
    for (int k = 0; k < 2; k++) send_byte(w[8*k +: 8], 0);
    bus.start_i = 1'b0;
    for (int k = 2; k < 4; k++) send_byte(w[8*k +: 8], 0);
    send_byte(8'h90, 0);
    bus.byte_valid_i = 1'b0;
    @(negedge clk);
    chk("reload_done", 32'(bus.done_o), 1);
    chk("reload_nwr",  32'(wa_q.size()), 2);
    if (wa_q.size() == 2) begin
      chk("reload_a0", 32'(wa_q[0]), 0);
      chk("reload_d0", wd_q[0], 32'h13);
      chk("reload_a1", 32'(wa_q[1]), 4);
      chk("reload_d1", wd_q[1], 32'h00100093);
    end
    chk("final_b2b", 32'(b2b), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
